shift_seq_ctrl: RTL and testbench

//   Multi-cycle sequencer for 32-bit RISC-V shifts (SLL/SRL/SRA) in the shifter path.

---
 rtl/shift_seq_ctrl.sv | 100 ++++++++++
 tb/tb_shift_seq_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle SLL/SRL/SRA sequencer: one right-shift datapath of at most STEP bits per cycle.
// Left shifts run as bit-reverse -> right shift -> bit-reverse.
module reverse_32bit (
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);
  for (genvar i = 0; i < 32; i++) begin : g_rev
    assign o_data[i] = i_data[31-i];
  end
endmodule

module shift_seq_ctrl #(
  parameter int STEP = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_data,
  input  logic [4:0]  i_shamt,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_data,
  output logic        o_busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [5:0] STEP_W = 6'(STEP);

  state_t      state_q;
  logic [1:0]  op_q;
  logic        sign_q;
  logic [4:0]  rem_q;
  logic [31:0] work_q;
  logic        o_valid_q;
  logic [31:0] o_data_q;

  logic [31:0] rev_in, rev_work;
  logic [4:0]  amt, rem_d;
  logic [32:0] ext_sh;
  logic [31:0] work_d;

  reverse_32bit u_rev_in   (.i_data(i_data), .o_data(rev_in));
  reverse_32bit u_rev_work (.i_data(work_q), .o_data(rev_work));

  // Sign bit rides as bit 32 so the arithmetic shift fills with it; zero for SLL/SRL.
  always_comb begin
    amt    = ({1'b0, rem_q} < STEP_W) ? rem_q : STEP_W[4:0];
    ext_sh = 33'($signed({sign_q, work_q}) >>> amt);
    work_d = ext_sh[31:0];
    rem_d  = rem_q - amt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      op_q      <= 2'b00;
      sign_q    <= 1'b0;
      rem_q     <= 5'd0;
      work_q    <= 32'd0;
      o_valid_q <= 1'b0;
      o_data_q  <= 32'd0;
    end else if (i_flush) begin
      state_q   <= IDLE;
      o_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (i_valid) begin
          op_q    <= i_op;
          sign_q  <= (i_op == OP_SRA) && i_data[31];
          rem_q   <= i_shamt;
          work_q  <= (i_op == OP_SLL) ? rev_in : i_data;
          state_q <= SHIFT;
        end
        SHIFT: if (rem_q == 5'd0) begin
          o_data_q <= (op_q == OP_SLL) ? rev_work : work_q;
          state_q  <= DONE;
        end else begin
          work_q <= work_d;
          rem_q  <= rem_d;
        end
        DONE: if (!o_valid_q) begin
          o_valid_q <= 1'b1;
        end else if (i_ready) begin
          o_valid_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready = (state_q == IDLE) && !i_flush;
  assign o_busy  = (state_q != IDLE);
  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Drives three sequencers (STEP 8, 1, 32) in lockstep and checks results and latency
// against plain shift arithmetic.
module tb_shift_seq_ctrl;
  logic        i_clk = 1'b0;
  logic        i_rst_n, i_flush, i_valid, i_ready;
  logic [1:0]  i_op;
  logic [31:0] i_data;
  logic [4:0]  i_shamt;
  logic [2:0]  ov, ordy, ob;
  logic [2:0][31:0] od;

  int checks = 0;
  int passed = 0;
  int steps[3] = '{8, 1, 32};

  always #5 i_clk = ~i_clk;

  shift_seq_ctrl #(.STEP(8)) u_s8 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(ordy[0]),
    .i_op(i_op), .i_data(i_data), .i_shamt(i_shamt), .o_valid(ov[0]), .i_ready(i_ready),
    .o_data(od[0]), .o_busy(ob[0]));
  shift_seq_ctrl #(.STEP(1)) u_s1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(ordy[1]),
    .i_op(i_op), .i_data(i_data), .i_shamt(i_shamt), .o_valid(ov[1]), .i_ready(i_ready),
    .o_data(od[1]), .o_busy(ob[1]));
  shift_seq_ctrl #(.STEP(32)) u_s32 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(ordy[2]),
    .i_op(i_op), .i_data(i_data), .i_shamt(i_shamt), .o_valid(ov[2]), .i_ready(i_ready),
    .o_data(od[2]), .o_busy(ob[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d,
                                        input logic [4:0] sh);
    case (op)
      2'b00:   return d << sh;
      2'b10:   return 32'($signed(d) >>> sh);
      default: return d >> sh;
    endcase
  endfunction

  task automatic start_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh);
    @(negedge i_clk);
    i_op = op; i_data = d; i_shamt = sh; i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_op = 2'($urandom); i_data = $urandom; i_shamt = 5'($urandom);
  endtask

  // Runs one op with i_ready high; checks each instance's result and cycles-to-valid.
  task automatic run_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh);
    logic [31:0] exp;
    logic [2:0]  seen;
    exp  = model(op, d, sh);
    seen = 3'b000;
    start_op(op, d, sh);
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(posedge i_clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (ov[k] && !seen[k]) begin
          seen[k] = 1'b1;
          chk($sformatf("data s%0d op%0d sh%0d", steps[k], op, sh), od[k], exp);
          chk($sformatf("lat s%0d sh%0d", steps[k], sh), 32'(cyc),
              32'(2 + (int'(sh) + steps[k] - 1) / steps[k]));
        end
      end
      if (&seen && ob == 3'b000) break;
    end
    chk("op_completed", 32'(seen), 32'h7);
  endtask

  logic [2:0]       anyv;
  logic [2:0][31:0] snap;

  initial begin
    i_rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_op = 2'b00; i_data = 32'd0; i_shamt = 5'd0;
    #1;
    chk("rst_valid", 32'(ov), 32'h0);
    chk("rst_busy",  32'(ob), 32'h0);
    chk("rst_data0", od[0], 32'h0);
    #20;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(ordy), 32'h7);

    run_op(2'b00, 32'h0000_0001, 5'd31);
    run_op(2'b10, 32'h8000_0000, 5'd4);
    run_op(2'b01, 32'h8000_0000, 5'd4);
    for (int op = 0; op < 4; op++) run_op(2'(op), 32'hDEAD_BEEF, 5'd0);
    run_op(2'b10, 32'hFFFF_0000, 5'd31);
    run_op(2'b00, 32'h1234_5678, 5'd8);

    // Backpressure in DONE
    i_ready = 1'b0;
    start_op(2'b00, 32'h1234_5678, 5'd5);
    for (int cyc = 0; cyc < 45 && ov != 3'b111; cyc++) begin
      @(posedge i_clk);
      #1;
    end
    chk("bp_valid_up", 32'(ov), 32'h7);
    snap = od;
    chk("bp_data", od[1], model(2'b00, 32'h1234_5678, 5'd5));
    repeat (5) begin
      @(posedge i_clk);
      #1;
      chk("bp_hold_valid", 32'(ov), 32'h7);
      chk("bp_hold_data0", od[0], snap[0]);
      chk("bp_hold_data2", od[2], snap[2]);
      chk("bp_no_ready", 32'(ordy), 32'h0);
    end
    @(negedge i_clk);
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    chk("bp_release_valid", 32'(ov), 32'h0);
    chk("bp_release_busy",  32'(ob), 32'h0);
    chk("bp_release_ready", 32'(ordy), 32'h7);
    chk("bp_data_kept", od[0], snap[0]);

    // Reset mid-operation
    start_op(2'b01, 32'hCAFE_F00D, 5'd31);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(ov), 32'h0);
    chk("mrst_busy",  32'(ob), 32'h0);
    chk("mrst_data0", od[0], 32'h0);
    chk("mrst_data1", od[1], 32'h0);
    chk("mrst_data2", od[2], 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    anyv = 3'b000;
    repeat (40) begin
      @(posedge i_clk);
      #1;
      anyv |= ov;
    end
    chk("mrst_no_valid", 32'(anyv), 32'h0);

    // Flush mid-operation; a request alongside flush is not taken
    run_op(2'b01, 32'hF0F0_F0F0, 5'd3);
    snap = od;
    start_op(2'b10, 32'h8765_4321, 5'd31);
    @(negedge i_clk);
    i_flush = 1'b1; i_valid = 1'b1;
    #1;
    chk("flush_ready_low", 32'(ordy), 32'h0);
    @(posedge i_clk);
    #1;
    chk("flush_busy", 32'(ob), 32'h0);
    @(negedge i_clk);
    chk("flush_req_ignored", 32'(ob), 32'h0);
    i_flush = 1'b0; i_valid = 1'b0;
    anyv = 3'b000;
    repeat (40) begin
      @(posedge i_clk);
      #1;
      anyv |= ov | ob;
    end
    chk("flush_no_valid", 32'(anyv), 32'h0);
    chk("flush_data0_kept", od[0], snap[0]);
    chk("flush_data1_kept", od[1], snap[1]);

    for (int n = 0; n < 1200; n++)
      run_op(2'($urandom), $urandom, 5'($urandom));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
